// File: rtl/demux_lane_scheduler_if.sv
// Handshake and lane-output bundle between the upstream producer, the
// demux_lane_scheduler and the four downstream lane consumers.
interface demux_lane_scheduler_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        credit_ret;
  logic [1:0]        sel;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic              stalled;
  logic              credit_err;

  // Upstream producer / downstream consumers side
  modport master (
    output in_valid, in_data, credit_ret,
    input  in_ready, sel, out_valid, out_data, stalled, credit_err
  );

  // Scheduler side
  modport slave (
    input  in_valid, in_data, credit_ret,
    output in_ready, sel, out_valid, out_data, stalled, credit_err
  );
endinterface

// File: rtl/demux_lane_scheduler.sv
// Credit-based round-robin lane scheduler in front of the 1-to-4 demux.
// Define DEMUX_SCHED_FIXED_PRIO_EN for fixed priority (lane 0 highest).
module demux_lane_scheduler #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CREDIT_MAX = 4
) (
  input logic                   clk,
  input logic                   rst,
  demux_lane_scheduler_if.slave bus
);

  localparam int unsigned CW    = $clog2(CREDIT_MAX + 1);
  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     credit_q [LANES];
  logic [CW-1:0]     credit_d [LANES];
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              stalled_q, stalled_d;
  logic              credit_err_q, credit_err_d;
`ifndef DEMUX_SCHED_FIXED_PRIO_EN
  logic [1:0]        ptr_q, ptr_d;
`endif

  logic [3:0]        eligible_c;
  logic              in_ready_c;
  logic [1:0]        cand_c;
  logic              grant_found_c;
  logic [1:0]        grant_lane_c;
  logic              transfer_c;

  // Eligibility from registered credits only, then first-eligible search
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      eligible_c[i] = (credit_q[i] != '0);
    end
    in_ready_c    = |eligible_c;
    cand_c        = '0;
    grant_found_c = 1'b0;
    grant_lane_c  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
`ifdef DEMUX_SCHED_FIXED_PRIO_EN
      cand_c = 2'(k);
`else
      cand_c = ptr_q + 2'(k + 1);
`endif
      if (!grant_found_c && eligible_c[cand_c]) begin
        grant_found_c = 1'b1;
        grant_lane_c  = cand_c;
      end
    end
    transfer_c = bus.in_valid & in_ready_c;
  end

  // Next-state, output and credit update
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    out_valid_d  = '0;
    out_data_d   = out_data_q;
    credit_err_d = credit_err_q;
`ifndef DEMUX_SCHED_FIXED_PRIO_EN
    ptr_d        = ptr_q;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
      credit_d[i] = credit_q[i];
    end

    if (!bus.in_valid) begin
      state_d = IDLE;
    end else if (transfer_c) begin
      state_d = ISSUE;
    end else begin
      state_d = STALL;
    end
    stalled_d = (state_d == STALL);

    if (transfer_c) begin
      out_valid_d = 4'(1) << grant_lane_c;
      sel_d       = grant_lane_c;
      out_data_d  = bus.in_data;
`ifndef DEMUX_SCHED_FIXED_PRIO_EN
      ptr_d       = grant_lane_c;
`endif
    end

    // A grant and a return on the same lane cancel; returns saturate at max
    for (int unsigned i = 0; i < LANES; i++) begin
      if (transfer_c && (grant_lane_c == 2'(i))) begin
        if (!bus.credit_ret[i]) begin
          credit_d[i] = credit_q[i] - CW'(1);
        end
      end else if (bus.credit_ret[i]) begin
        if (credit_q[i] == CW'(CREDIT_MAX)) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      out_valid_q  <= '0;
      out_data_q   <= '0;
      stalled_q    <= 1'b0;
      credit_err_q <= 1'b0;
`ifndef DEMUX_SCHED_FIXED_PRIO_EN
      ptr_q        <= 2'd3;
`endif
      for (int unsigned i = 0; i < LANES; i++) begin
        credit_q[i] <= CW'(CREDIT_MAX);
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      stalled_q    <= stalled_d;
      credit_err_q <= credit_err_d;
`ifndef DEMUX_SCHED_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
      for (int unsigned i = 0; i < LANES; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.sel        = sel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.stalled    = stalled_q;
  assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Bench for demux_lane_scheduler: directed test-plan sequences followed by
// random traffic, all compared against a transaction-level credit model.
module tb_demux_lane_scheduler;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CREDIT_MAX = 4;

  logic clk = 1'b0;
  logic rst;

  demux_lane_scheduler_if #(.DATA_W(DATA_W)) bus ();

  demux_lane_scheduler #(
    .DATA_W    (DATA_W),
    .CREDIT_MAX(CREDIT_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int accepted = 0;

  // Reference model state
  int          m_credit [4];
  int          m_ptr;
  bit          m_err;
  logic [3:0]  m_ov;
  logic [1:0]  m_sel;
  logic [7:0]  m_data;
  bit          m_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_credit[i] = CREDIT_MAX;
    m_ptr   = 3;
    m_err   = 1'b0;
    m_ov    = '0;
    m_sel   = '0;
    m_data  = '0;
    m_stall = 1'b0;
  endfunction

  function automatic bit m_ready();
    return (m_credit[0] > 0) || (m_credit[1] > 0) || (m_credit[2] > 0) || (m_credit[3] > 0);
  endfunction

  task automatic check_outputs(input string where);
    check_eq({where, ".out_valid"},  32'(bus.out_valid),  32'(m_ov));
    check_eq({where, ".sel"},        32'(bus.sel),        32'(m_sel));
    check_eq({where, ".out_data"},   32'(bus.out_data),   32'(m_data));
    check_eq({where, ".stalled"},    32'(bus.stalled),    32'(m_stall));
    check_eq({where, ".credit_err"}, 32'(bus.credit_err), 32'(m_err));
    check_eq({where, ".in_ready"},   32'(bus.in_ready),   32'(m_ready()));
  endtask

  // One clock cycle: check the present outputs, apply inputs, advance the model
  task automatic step(input string where, input bit v, input logic [7:0] d, input logic [3:0] cr);
    int g;
    bit rdy;
    @(negedge clk);
    check_outputs(where);
    if (v && bus.in_ready) accepted++;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.credit_ret = cr;

    rdy = m_ready();
    g   = -1;
    if (v && rdy) begin
      for (int k = 0; k < 4; k++) begin
        int lane;
`ifdef DEMUX_SCHED_FIXED_PRIO_EN
        lane = k;
`else
        lane = (m_ptr + 1 + k) % 4;
`endif
        if (g < 0 && m_credit[lane] > 0) g = lane;
      end
    end
    m_stall = v && !rdy;
    if (g >= 0) begin
      m_ov   = 4'(1 << g);
      m_sel  = 2'(g);
      m_data = d;
      m_ptr  = g;
    end else begin
      m_ov = '0;
    end
    for (int i = 0; i < 4; i++) begin
      if (g == i && cr[i]) begin
        // grant and return cancel
      end else if (g == i) begin
        m_credit[i]--;
      end else if (cr[i]) begin
        if (m_credit[i] == CREDIT_MAX) m_err = 1'b1;
        else m_credit[i]++;
      end
    end
  endtask

  initial begin
    logic [3:0] cr;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.credit_ret = '0;
    m_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill: first four words hit lanes 0..3, then exactly 4*CREDIT_MAX accepted
    accepted = 0;
    for (int i = 0; i < 20; i++) step("stream", 1'b1, 8'(8'hA0 + i), 4'b0000);
    check_eq("accepted_words", 32'(accepted), 32'(4 * CREDIT_MAX));

    // Single credit back on lane 2 from the empty state
    step("ret2", 1'b1, 8'hB0, 4'b0100);
    step("ret2", 1'b1, 8'hB1, 4'b0000);
    step("ret2", 1'b1, 8'hB2, 4'b0000);
    check_eq("lane2_word", 32'(bus.out_valid), 32'(4'b0100));
    step("ret2", 1'b1, 8'hB3, 4'b0000);
    step("ret2", 1'b0, 8'hB4, 4'b0000);

    // Grant and return on lane 1 in the same cycle, then overfill lane 3
    step("g1", 1'b0, 8'h00, 4'b0010);
    step("g1", 1'b1, 8'hC0, 4'b0010);
    step("g1", 1'b1, 8'hC1, 4'b0000);
    step("g1", 1'b1, 8'hC2, 4'b0000);
    step("g1", 1'b0, 8'hC3, 4'b0000);
    for (int i = 0; i < 5; i++) step("err3", 1'b0, 8'h00, 4'b1000);
    step("err3", 1'b0, 8'h00, 4'b0000);
    step("err3", 1'b0, 8'h00, 4'b0000);

    // Asynchronous reset between two accepted words
    step("prerst", 1'b0, 8'h00, 4'b1111);
    step("prerst", 1'b1, 8'hD0, 4'b0000);
    step("prerst", 1'b1, 8'hD1, 4'b0000);
    @(posedge clk);
    #2;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.credit_ret = '0;
    #1;
    m_reset();
    check_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("postrst", 1'b1, 8'hE0, 4'b0000);
    step("postrst", 1'b1, 8'hE1, 4'b0000);
    check_eq("postrst_lane0", 32'(bus.out_valid), 32'(4'b0001));

    // Lane 0 refreshed every cycle
    for (int i = 0; i < 12; i++) step("keep0", 1'b1, 8'(8'h60 + i), 4'b0001);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) cr[b] = ($urandom_range(0, 3) == 0);
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), cr);
    end
    step("tail", 1'b0, 8'h00, 4'b0000);
    @(negedge clk);
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
